// File: rtl/proc_sequencer.sv
// proc_sequencer
//
// Sequences a simple processor from a synchronous program ROM. Instructions
// are fetched one at a time and handed to the processor with a one-cycle Run
// strobe. An mvi instruction (opcode 3'b001) is followed by its immediate word
// on the next cycle. The sequencer then waits for Done before fetching the
// next instruction. Opcode 3'b111 halts the program. A processor that never
// raises Done causes an error after TIMEOUT wait cycles.
//
// Parameters
//   ADDR_W      program-memory address width (2**ADDR_W words)
//   TIMEOUT     maximum wait cycles for Done before Error (1..255)
//
// Ports
//   Clock       single clock, rising edge
//   Reset       synchronous, active-high reset
//   Start       one-cycle pulse, begins execution at StartAddr
//   StartAddr   first program address, sampled only when Start is accepted
//   MemData     ROM word, valid one cycle after MemAddr is presented
//   Done        processor completion flag
//   MemAddr     ROM address (the program counter)
//   DIN         instruction/immediate word driven to the processor
//   Run         processor start strobe
//   Busy        executing (FETCH/ISSUE/IMM/WAIT)
//   Halted      program reached a HALT instruction
//   Error       processor did not signal Done in time
//   InstrCount  instructions issued since the last accepted Start (saturates)

module proc_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic [8:0]        MemData,
  input  logic              Done,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [8:0]        DIN,
  output logic              Run,
  output logic              Busy,
  output logic              Halted,
  output logic              Error,
  output logic [7:0]        InstrCount
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    IMM,
    WAIT,
    HALT,
    ERR
  } state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT);
  localparam logic [2:0] OP_MVI        = 3'b001;
  localparam logic [2:0] OP_HALT       = 3'b111;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        waitCount;
  logic              isHaltOp;
  logic              isMviOp;

  // The ROM word on MemData belongs to the address presented in the previous
  // cycle, so in ISSUE it is the instruction fetched in FETCH and in IMM it is
  // the word following the mvi.
  assign isHaltOp = (MemData[8:6] == OP_HALT);
  assign isMviOp  = (MemData[8:6] == OP_MVI);

  // Main sequencing state machine. Reset wins over Start and Done. The PC is
  // advanced once in FETCH and once more for an mvi so that the immediate word
  // is skipped; both increments wrap naturally at the address width. The wait
  // counter is cleared on every entry to WAIT so each instruction gets its own
  // full timeout window, and Done on the last allowed WAIT cycle still counts.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      pc         <= '0;
      waitCount  <= '0;
      InstrCount <= '0;
    end else begin
      case (state)
        IDLE, HALT, ERR: begin
          if (Start) begin
            pc         <= StartAddr;
            InstrCount <= '0;
            state      <= FETCH;
          end
        end
        FETCH: begin
          pc    <= pc + 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          if (isHaltOp) begin
            state <= HALT;
          end else begin
            if (InstrCount != 8'hFF) begin
              InstrCount <= InstrCount + 8'd1;
            end
            if (isMviOp) begin
              pc    <= pc + 1'b1;
              state <= IMM;
            end else begin
              waitCount <= '0;
              state     <= WAIT;
            end
          end
        end
        IMM: begin
          if (Done) begin
            state <= FETCH;
          end else begin
            waitCount <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (Done) begin
            state <= FETCH;
          end else if (waitCount == TIMEOUT_LIMIT) begin
            state <= ERR;
          end else begin
            waitCount <= waitCount + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Processor-facing outputs. Run and DIN follow the ROM word in the same
  // cycle it arrives, which keeps the Start-to-Run latency at two cycles.
  always_comb begin
    Run = 1'b0;
    DIN = '0;
    if (state == ISSUE && !isHaltOp) begin
      Run = 1'b1;
      DIN = MemData;
    end else if (state == IMM) begin
      DIN = MemData;
    end
  end

  // Status flags are plain decodes of the registered state.
  assign MemAddr = pc;
  assign Busy    = (state == FETCH) || (state == ISSUE) ||
                   (state == IMM)   || (state == WAIT);
  assign Halted  = (state == HALT);
  assign Error   = (state == ERR);

endmodule

// File: tb/tb_proc_sequencer.sv
// tb_proc_sequencer
//
// Self-checking bench for proc_sequencer. A synchronous ROM model feeds the
// DUT. For each program run a reference model walks the program with the
// instruction rules and the per-instruction Done delays and builds the
// expected per-cycle view (Run, DIN, MemAddr, Busy, InstrCount, Done drive)
// plus the final status. Directed programs cover the documented scenarios;
// random programs with random Done delays cover the rest.

module tb_proc_sequencer;

  localparam int ADDR_W  = 5;
  localparam int TIMEOUT = 15;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              Clock;
  logic              Reset;
  logic              Start;
  logic [ADDR_W-1:0] StartAddr;
  logic [8:0]        MemData;
  logic              Done;
  logic [ADDR_W-1:0] MemAddr;
  logic [8:0]        DIN;
  logic              Run;
  logic              Busy;
  logic              Halted;
  logic              Error;
  logic [7:0]        InstrCount;

  int checks = 0;
  int errors = 0;

  logic [8:0] rom [0:DEPTH-1];

  // Done delay per issued instruction, counted in cycles from the Run cycle.
  // Zero means Done is never raised for that instruction.
  int delayPlan[$];
  int defaultDelay = 3;

  // Expected per-cycle trace, starting with the cycle after Start.
  logic              expRun[$];
  logic [8:0]        expDin[$];
  logic [ADDR_W-1:0] expAddr[$];
  logic [7:0]        expCnt[$];
  logic              expDone[$];
  logic              expIgnore[$];

  int                finalKind;
  logic [ADDR_W-1:0] finalPc;
  logic [7:0]        finalCnt;

  proc_sequencer #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .StartAddr (StartAddr),
    .MemData   (MemData),
    .Done      (Done),
    .MemAddr   (MemAddr),
    .DIN       (DIN),
    .Run       (Run),
    .Busy      (Busy),
    .Halted    (Halted),
    .Error     (Error),
    .InstrCount(InstrCount)
  );

  // Free-running clock.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Synchronous program ROM: data one cycle after the address.
  always @(posedge Clock) begin
    MemData <= rom[MemAddr];
  end

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pushCycle(input logic run, input logic [8:0] din, input logic [ADDR_W-1:0] addr,
                           input logic [7:0] cnt, input logic done, input logic ign);
    expRun.push_back(run);
    expDin.push_back(din);
    expAddr.push_back(addr);
    expCnt.push_back(cnt);
    expDone.push_back(done);
    expIgnore.push_back(ign);
  endtask

  // Reference model: walks the program and lays out the expected cycles.
  // finalKind: 0 halted, 1 timed out, 2 stopped after cap instructions.
  task automatic buildModel(input logic [ADDR_W-1:0] sa, input int cap);
    logic [ADDR_W-1:0] mpc;
    logic [8:0]        instr;
    logic [7:0]        cnt;
    int                n;
    int                d;
    int                first;
    bit                isMvi;
    bit                finished;
    bit                hit;
    expRun.delete();
    expDin.delete();
    expAddr.delete();
    expCnt.delete();
    expDone.delete();
    expIgnore.delete();
    mpc = sa;
    cnt = 8'd0;
    n = 0;
    finalKind = 2;
    while (n < cap) begin
      pushCycle(1'b0, 9'd0, mpc, cnt, 1'b0, 1'b1);
      instr = rom[mpc];
      mpc = mpc + 1'b1;
      if (instr[8:6] == 3'b111) begin
        pushCycle(1'b0, 9'd0, mpc, cnt, 1'b0, 1'b1);
        finalKind = 0;
        break;
      end
      isMvi = (instr[8:6] == 3'b001);
      d = (delayPlan.size() > 0) ? delayPlan.pop_front() : defaultDelay;
      pushCycle(1'b1, instr, mpc, cnt, 1'b0, 1'b1);
      if (cnt != 8'd255) cnt = cnt + 8'd1;
      n++;
      if (isMvi) begin
        instr = rom[mpc];
        mpc = mpc + 1'b1;
        pushCycle(1'b0, instr, mpc, cnt, d == 1, 1'b0);
        if (d == 1) continue;
      end
      first = isMvi ? 2 : 1;
      finished = 1'b0;
      for (int j = 0; j <= TIMEOUT; j++) begin
        hit = (d == first + j);
        pushCycle(1'b0, 9'd0, mpc, cnt, hit, 1'b0);
        if (hit) begin
          finished = 1'b1;
          break;
        end
      end
      if (!finished) begin
        finalKind = 1;
        break;
      end
    end
    finalPc  = mpc;
    finalCnt = cnt;
  endtask

  // Starts a program and compares every cycle against the model. limit >= 0
  // stops after that many cycles without final checks; pokeAt pulses Start
  // during that busy cycle; noise drives random Done in FETCH/ISSUE cycles.
  task automatic applyStimulus(input logic [ADDR_W-1:0] sa, input int cap, input int limit,
                               input int pokeAt, input bit noise, input string tag);
    int n;
    buildModel(sa, cap);
    n = expRun.size();
    if (limit >= 0 && limit < n) n = limit;
    Start = 1'b1;
    StartAddr = sa;
    Done = 1'b0;
    @(posedge Clock); #1;
    Start = 1'b0;
    StartAddr = ADDR_W'($urandom);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s c%0d Run", tag, i), 32'(Run), 32'(expRun[i]));
      checkOutput($sformatf("%s c%0d DIN", tag, i), 32'(DIN), 32'(expDin[i]));
      checkOutput($sformatf("%s c%0d MemAddr", tag, i), 32'(MemAddr), 32'(expAddr[i]));
      checkOutput($sformatf("%s c%0d Busy", tag, i), 32'(Busy), 32'd1);
      checkOutput($sformatf("%s c%0d InstrCount", tag, i), 32'(InstrCount), 32'(expCnt[i]));
      checkOutput($sformatf("%s c%0d Halted", tag, i), 32'(Halted), 32'd0);
      checkOutput($sformatf("%s c%0d Error", tag, i), 32'(Error), 32'd0);
      if (expIgnore[i] && noise) Done = 1'($urandom);
      else Done = expDone[i];
      if (i == pokeAt) begin
        Start = 1'b1;
        StartAddr = ADDR_W'($urandom);
      end
      @(posedge Clock); #1;
      Start = 1'b0;
      Done = 1'b0;
    end
    if (limit < 0) begin
      if (finalKind == 2) begin
        checkOutput({tag, " cap Busy"}, 32'(Busy), 32'd1);
        checkOutput({tag, " cap InstrCount"}, 32'(InstrCount), 32'(finalCnt));
      end else begin
        for (int k = 0; k < 2; k++) begin
          checkOutput($sformatf("%s end%0d Halted", tag, k), 32'(Halted), 32'(finalKind == 0));
          checkOutput($sformatf("%s end%0d Error", tag, k), 32'(Error), 32'(finalKind == 1));
          checkOutput($sformatf("%s end%0d Busy", tag, k), 32'(Busy), 32'd0);
          checkOutput($sformatf("%s end%0d Run", tag, k), 32'(Run), 32'd0);
          checkOutput($sformatf("%s end%0d DIN", tag, k), 32'(DIN), 32'd0);
          checkOutput($sformatf("%s end%0d MemAddr", tag, k), 32'(MemAddr), 32'(finalPc));
          checkOutput($sformatf("%s end%0d InstrCount", tag, k), 32'(InstrCount), 32'(finalCnt));
          // Done in a terminal state must not move anything.
          Done = 1'b1;
          @(posedge Clock); #1;
          Done = 1'b0;
        end
      end
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " Run"}, 32'(Run), 32'd0);
    checkOutput({tag, " DIN"}, 32'(DIN), 32'd0);
    checkOutput({tag, " Busy"}, 32'(Busy), 32'd0);
    checkOutput({tag, " Halted"}, 32'(Halted), 32'd0);
    checkOutput({tag, " Error"}, 32'(Error), 32'd0);
    checkOutput({tag, " MemAddr"}, 32'(MemAddr), 32'd0);
    checkOutput({tag, " InstrCount"}, 32'(InstrCount), 32'd0);
  endtask

  task automatic fillRandomProgram();
    int h;
    for (int a = 0; a < DEPTH; a++) begin
      rom[a] = {3'($urandom_range(0, 6)), 6'($urandom)};
    end
    // Two adjacent halts so a skipped immediate cannot step over both.
    h = $urandom_range(0, DEPTH - 1);
    rom[h] = 9'o700;
    rom[(h + 1) % DEPTH] = 9'o701;
  endtask

  // Directed scenarios followed by randomized programs.
  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    StartAddr = '0;
    Done = 1'b0;
    for (int a = 0; a < DEPTH; a++) rom[a] = 9'o700;

    repeat (3) @(posedge Clock);
    #1;
    checkIdle("reset");
    Reset = 1'b0;
    @(posedge Clock); #1;
    checkIdle("idle");

    // Single add then halt.
    rom[0] = 9'o012;
    rom[1] = 9'o700;
    delayPlan.delete();
    delayPlan.push_back(3);
    applyStimulus(5'd0, 1000, -1, -1, 1'b0, "addhalt");
    checkOutput("addhalt MemAddr", 32'(MemAddr), 32'd2);
    checkOutput("addhalt InstrCount", 32'(InstrCount), 32'd1);

    // mvi with immediate, Done in WAIT and then Done during IMM.
    rom[4] = 9'o110;
    rom[5] = 9'o123;
    rom[6] = 9'o700;
    delayPlan.delete();
    delayPlan.push_back(4);
    applyStimulus(5'd4, 1000, -1, -1, 1'b0, "mvi");
    checkOutput("mvi MemAddr", 32'(MemAddr), 32'd7);
    checkOutput("mvi InstrCount", 32'(InstrCount), 32'd1);
    delayPlan.delete();
    delayPlan.push_back(1);
    applyStimulus(5'd4, 1000, -1, -1, 1'b0, "mvi-immdone");

    // Address wrap across the top of the ROM.
    rom[30] = 9'o012;
    rom[31] = 9'o110;
    rom[0]  = 9'o055;
    rom[1]  = 9'o700;
    delayPlan.delete();
    delayPlan.push_back(2);
    delayPlan.push_back(3);
    applyStimulus(5'd30, 1000, -1, -1, 1'b0, "wrap");
    checkOutput("wrap MemAddr", 32'(MemAddr), 32'd2);
    checkOutput("wrap InstrCount", 32'(InstrCount), 32'd2);

    // Timeout, restart from Error, Done on the last allowed cycle.
    rom[0] = 9'o012;
    rom[1] = 9'o700;
    delayPlan.delete();
    delayPlan.push_back(0);
    applyStimulus(5'd0, 1000, -1, -1, 1'b0, "timeout");
    checkOutput("timeout Error", 32'(Error), 32'd1);
    delayPlan.delete();
    delayPlan.push_back(TIMEOUT + 1);
    applyStimulus(5'd0, 1000, -1, -1, 1'b0, "lastwait");
    checkOutput("lastwait Halted", 32'(Halted), 32'd1);
    rom[2] = 9'o110;
    rom[3] = 9'o777;
    rom[4] = 9'o700;
    delayPlan.delete();
    delayPlan.push_back(TIMEOUT + 2);
    applyStimulus(5'd2, 1000, -1, -1, 1'b0, "mvi-lastwait");

    // Start during WAIT is ignored.
    rom[12] = 9'o012;
    rom[13] = 9'o700;
    delayPlan.delete();
    delayPlan.push_back(6);
    applyStimulus(5'd12, 1000, -1, 3, 1'b0, "startinwait");

    // Reset mid-WAIT with three instructions issued, Start in the same cycle.
    rom[8]  = 9'o012;
    rom[9]  = 9'o023;
    rom[10] = 9'o034;
    rom[11] = 9'o700;
    delayPlan.delete();
    delayPlan.push_back(1);
    delayPlan.push_back(1);
    delayPlan.push_back(0);
    applyStimulus(5'd8, 1000, 10, -1, 1'b0, "midwait");
    checkOutput("midwait InstrCount", 32'(InstrCount), 32'd3);
    checkOutput("midwait Busy", 32'(Busy), 32'd1);
    Reset = 1'b1;
    Start = 1'b1;
    StartAddr = 5'd20;
    Done = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    Start = 1'b0;
    Done = 1'b0;
    checkIdle("midwait reset");
    @(posedge Clock); #1;
    checkIdle("midwait after");

    // InstrCount saturation on an endless program.
    for (int a = 0; a < DEPTH; a++) rom[a] = 9'o012;
    delayPlan.delete();
    defaultDelay = 1;
    applyStimulus(5'd17, 260, -1, -1, 1'b0, "saturate");
    checkOutput("saturate InstrCount", 32'(InstrCount), 32'd255);
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    checkIdle("saturate reset");
    defaultDelay = 3;

    // Random programs, Done delays, ignored Done noise and stray Starts.
    for (int t = 0; t < 12; t++) begin
      fillRandomProgram();
      delayPlan.delete();
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(0, 24) == 0) delayPlan.push_back(0);
        else delayPlan.push_back($urandom_range(1, TIMEOUT + 2));
      end
      applyStimulus(ADDR_W'($urandom), 1000, -1, $urandom_range(0, 6), 1'b1,
                    $sformatf("rand%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/proc_sequencer.md
PROC_SEQUENCER -- requirements
Module: proc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 5, program-memory address width (memory depth 2**ADDR_W words).
REQ-002 Parameter TIMEOUT, default 15, maximum cycles spent waiting for Done before Error; legal range 1..255.
REQ-003 Clock  input  1  single clock; every register updates on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  one-cycle pulse; begins execution at StartAddr.
REQ-006 StartAddr  input  ADDR_W  first program address, sampled only when Start is accepted.
REQ-007 MemData  input  9  word from synchronous program ROM; valid one cycle after MemAddr is presented.
REQ-008 Done  input  1  processor completion flag.
REQ-009 MemAddr  output  ADDR_W  program-ROM address; equals the PC register combinationally.
REQ-010 DIN  output  9  instruction/immediate word driven to the processor.
REQ-011 Run  output  1  processor start strobe.
REQ-012 Busy, Halted, Error  output  1 each  status flags.
REQ-013 InstrCount  output  8  number of instructions issued since the last accepted Start.

Function
REQ-014 States SHALL be IDLE, FETCH, ISSUE, IMM, WAIT, HALT, ERR; encoding is free.
REQ-015 IDLE/HALT/ERR + Start: PC<=StartAddr, InstrCount<=0, Halted<=0, Error<=0, ->FETCH; Start ignored in all other states.
REQ-016 FETCH (1 cycle): MemAddr=PC; PC<=PC+1; ->ISSUE.
REQ-017 ISSUE, MemData[8:6]==3'b111 (HALT): Run=0, DIN=0, PC unchanged, ->HALT.
REQ-018 ISSUE, other opcodes: DIN=MemData, Run=1 for exactly this cycle, InstrCount+=1 (saturating at 255).
REQ-019 ISSUE, opcode 3'b001 (mvi): PC<=PC+1, ->IMM; all other opcodes ->WAIT.
REQ-020 IMM (1 cycle): DIN=MemData (immediate word at instruction address+1), Run=0, ->WAIT.
REQ-021 In IMM a sampled Done=1 SHALL count as completion: next state FETCH instead of WAIT.
REQ-022 WAIT: DIN=0, Run=0; Done=1 ->FETCH; wait counter cleared on entry to WAIT and incremented each WAIT cycle.
REQ-023 WAIT with counter==TIMEOUT and Done=0 ->ERR; Done=1 in that same cycle takes precedence (->FETCH).
REQ-024 Done outside IMM/WAIT SHALL be ignored.
REQ-025 PC is ADDR_W bits and SHALL wrap (2**ADDR_W-1)+1 -> 0 in both FETCH and the mvi increment.
REQ-026 DIN=0 and Run=0 in every state except ISSUE/IMM as stated above.
REQ-027 Busy=1 in FETCH, ISSUE, IMM, WAIT; Halted=1 only in HALT; Error=1 only in ERR; all flags are registered-state decodes.
REQ-028 Latency: Start pulse at cycle N -> MemAddr=StartAddr at N+1, Run at N+2 (non-HALT word).

Reset
REQ-029 Reset=1 at any edge, including mid-instruction: state<=IDLE, PC<=0, wait counter<=0, InstrCount<=0; Run=0, DIN=0, Busy=0, Halted=0, Error=0 from the next cycle.
REQ-030 Reset SHALL take priority over Start and Done in the same cycle.

Verification
REQ-031 ROM[0]=9'o012 (add), Done 3 cycles after Run, ROM[1]=9'o700, Start with StartAddr=0 -> one Run pulse with DIN=9'o012, then Halted=1, InstrCount=1, MemAddr=2.
REQ-032 ROM[4]=9'o110 (mvi), ROM[5]=9'o123, ROM[6]=HALT, Start with StartAddr=4 -> Run with DIN=9'o110, next cycle DIN=9'o123 and Run=0, next fetch from address 6, InstrCount=1.
REQ-033 Program at addresses 30, 31, 0 (mvi at 31, immediate at 0) -> PC wraps 31->0, immediate taken from address 0, next fetch from address 1.
REQ-034 Done never asserted -> Error=1 exactly TIMEOUT+1 cycles after WAIT entry; Start with StartAddr=0 clears Error and restarts. Done asserted on the final WAIT cycle -> no Error.
REQ-035 Reset asserted in WAIT with InstrCount=3 -> next cycle IDLE, all outputs 0; a Start pulse in the same cycle as Reset is ignored.
REQ-036 Start pulse in WAIT -> no effect on PC, InstrCount or state.
